mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised, multi-cycle multiply/divide unit that extends the combinational integer ALU with the RV32M operation set.
- Sits beside the ALU in the execute stage. It accepts one operation through a valid/ready handshake, iterates one bit per cycle, and returns the result with a tag for writeback.
- Width is a parameter; signed, unsigned and mixed-sign forms are all supported.

Parameters:
- DATA_WIDTH, 32, operand and result width W (even, >= 8).
- TAG_WIDTH, 5, width of the opaque tag carried from request to result (destination register index).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- flush_i  input  1  kill the in-flight or pending operation (pipeline flush).
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  unit idle, can accept a request.
- op_i  input  3  operation, RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src1_i  input  DATA_WIDTH  operand 1: multiplicand or dividend.
- src2_i  input  DATA_WIDTH  operand 2: multiplier or divisor.
- tag_i  input  TAG_WIDTH  request tag.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- result_o  output  DATA_WIDTH  result.
- tag_o  output  TAG_WIDTH  tag of result_o.

Behaviour:
- States: IDLE, CALC, DONE.
- in_ready_o = (state == IDLE). out_valid_o = (state == DONE).
- Reset: state IDLE; out_valid_o 0; result_o 0; tag_o 0; counter 0.
- Reset has priority over everything and aborts any operation, including mid-operation.
- Accept: an edge with in_valid_i & in_ready_o & !flush_i latches op_i, the operands and tag_i.
  - Absolute values are latched for signed operands; result sign flags are recorded.
  - State moves to CALC and the counter is cleared.
- CALC:
  - Multiply: unsigned shift-add on the 2W-bit product, one bit per edge.
  - Divide: restoring division on absolute values, one quotient bit per edge.
  - After exactly W CALC edges, sign fixup is applied and result_o/tag_o are registered; state moves to DONE.
  - out_valid_o is first high W edges after the accepting edge (32 for W = 32).
- Sign rules:
  - MUL returns the low W bits.
  - MULH treats both operands as signed; MULHSU treats src1 as signed and src2 as unsigned; MULHU treats both as unsigned. All three return the high W bits.
  - Quotient sign = sign1 ^ sign2. Remainder takes the dividend's sign.
- Special cases (result mandatory regardless of datapath):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return src1.
  - Signed overflow (src1 = 1 followed by zeros, src2 = all-ones): DIV returns src1; REM returns 0.
- DONE:
  - result_o and tag_o are held stable while out_ready_i = 0.
  - An edge with out_ready_i = 1 returns the unit to IDLE; in_ready_o is high the following cycle.
  - No same-cycle result-to-request bypass.
- flush_i:
  - In any state, the next edge goes to IDLE and out_valid_o drops; the result is discarded.
  - flush_i wins over a simultaneous accept, and the request is dropped.
  - In DONE with out_ready_i = 1 and flush_i = 1, the unit still returns to IDLE (no double handshake issue).
- in_valid_i while busy is ignored; the requester holds its request until in_ready_o.

Optional Feature:
- Macro: MDU_FAST_SPECIAL_EN.
- When defined, the following cases go from accept directly to DONE, with out_valid_o high 1 edge after acceptance and results per the special-case rules:
  - divide by zero;
  - signed overflow;
  - any multiply with a zero operand.
- When undefined, every operation takes exactly W CALC edges; results are identical.

Test Plan:
- MUL 0x00000007 × 0xFFFFFFFD -> result_o 0xFFFFFFEB; out_valid_o exactly 32 edges after accept; tag 0x0A returned.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF. REMU 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Latency 1 edge with MDU_FAST_SPECIAL_EN, 32 without.
- Backpressure: out_ready_i low 5 cycles in DONE -> result_o/tag_o stable, in_ready_o 0, and a new in_valid_i is not accepted. out_ready_i high -> in_ready_o 1 next cycle; back-to-back op correct.
- Flush/reset: flush_i at CALC edge 10 -> out_valid_o never asserts, in_ready_o 1 next cycle, next DIVU 9 / 3 -> 3. rst_i mid-CALC -> all outputs reset values next cycle.

Source files
------------

// File: rtl/mdu_iter.sv
// ============================================================================
// Module      : mdu_iter
// Description : Iterative RV32M multiply/divide unit, one bit per cycle,
//               valid/ready request and result handshakes with a carried tag.
//               Optional macro MDU_FAST_SPECIAL_EN shortcuts trivial cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] src1_i,
    input  logic [DATA_WIDTH-1:0] src2_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [TAG_WIDTH-1:0]  tag_o
);

    localparam int                 c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [2:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic                    r_neg;
    logic [TAG_WIDTH-1:0]    r_tag_in;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [TAG_WIDTH-1:0]    r_tag_out;

    // Request decode: signedness of each operand, magnitudes and result sign.
    logic                    w_is_div;
    logic                    w_s1_signed;
    logic                    w_s2_signed;
    logic                    w_neg1;
    logic                    w_neg2;
    logic                    w_div0;
    logic                    w_neg_res;
    logic [DATA_WIDTH-1:0]   w_abs1;
    logic [DATA_WIDTH-1:0]   w_abs2;

    assign w_is_div    = op_i[2];
    assign w_s1_signed = w_is_div ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
    assign w_s2_signed = w_is_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
    assign w_neg1      = w_s1_signed & src1_i[DATA_WIDTH-1];
    assign w_neg2      = w_s2_signed & src2_i[DATA_WIDTH-1];
    assign w_abs1      = w_neg1 ? -src1_i : src1_i;
    assign w_abs2      = w_neg2 ? -src2_i : src2_i;
    assign w_div0      = (src2_i == '0);

    // The all-ones quotient of a zero divisor must never be sign-flipped.
    always_comb begin
        w_neg_res = w_neg1 ^ w_neg2;
        if (w_is_div) begin
            if (op_i[1])
                w_neg_res = w_neg1;
            else
                w_neg_res = (w_neg1 ^ w_neg2) & ~w_div0;
        end
    end

`ifdef MDU_FAST_SPECIAL_EN
    logic                  r_fast;
    logic [DATA_WIDTH-1:0] r_fast_res;
    logic                  w_ovf;
    logic                  w_fast_hit;
    logic [DATA_WIDTH-1:0] w_fast_res;

    assign w_ovf      = w_is_div & ~op_i[0] & (src2_i == '1) &
                        (src1_i == {1'b1, {(DATA_WIDTH-1){1'b0}}});
    assign w_fast_hit = w_is_div ? (w_div0 | w_ovf) : (src1_i == '0 || src2_i == '0);

    always_comb begin
        w_fast_res = '0;
        if (w_is_div) begin
            if (w_div0)
                w_fast_res = op_i[1] ? src1_i : '1;
            else
                w_fast_res = op_i[1] ? '0 : src1_i;
        end
    end
`endif

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [DATA_WIDTH:0]     w_diff;
    logic [DATA_WIDTH-1:0]   w_next_hi;
    logic [DATA_WIDTH-1:0]   w_next_lo;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_diff    = {r_hi, r_lo[DATA_WIDTH-1]} - {1'b0, r_a};

    always_comb begin
        w_next_hi = '0;
        w_next_lo = '0;
        if (r_op[2]) begin
            if (!w_diff[DATA_WIDTH]) begin
                w_next_hi = w_diff[DATA_WIDTH-1:0];
                w_next_lo = {r_lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                w_next_hi = {r_hi[DATA_WIDTH-2:0], r_lo[DATA_WIDTH-1]};
                w_next_lo = {r_lo[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            w_next_hi = w_mul_sum[DATA_WIDTH:1];
            w_next_lo = {w_mul_sum[0], r_lo[DATA_WIDTH-1:1]};
        end
    end

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0]   w_quot;
    logic [DATA_WIDTH-1:0]   w_rem;
    logic [DATA_WIDTH-1:0]   w_final;

    assign w_prod     = {w_next_hi, w_next_lo};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_quot     = r_neg ? -w_next_lo : w_next_lo;
    assign w_rem      = r_neg ? -w_next_hi : w_next_hi;

    always_comb begin
        w_final = '0;
        case (r_op)
            3'b000:                 w_final = w_prod_fix[DATA_WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            3'b100, 3'b101:         w_final = w_quot;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg     <= 1'b0;
            r_tag_in  <= '0;
            r_result  <= '0;
            r_tag_out <= '0;
`ifdef MDU_FAST_SPECIAL_EN
            r_fast     <= 1'b0;
            r_fast_res <= '0;
`endif
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_state  <= S_CALC;
                        r_cnt    <= '0;
                        r_op     <= op_i;
                        r_tag_in <= tag_i;
                        r_neg    <= w_neg_res;
                        r_hi     <= '0;
                        r_a      <= w_is_div ? w_abs2 : w_abs1;
                        r_lo     <= w_is_div ? w_abs1 : w_abs2;
`ifdef MDU_FAST_SPECIAL_EN
                        r_fast     <= w_fast_hit;
                        r_fast_res <= w_fast_res;
                        if (w_fast_hit)
                            r_cnt <= c_LAST;
`endif
                    end
                end
                S_CALC: begin
                    r_hi  <= w_next_hi;
                    r_lo  <= w_next_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
`ifdef MDU_FAST_SPECIAL_EN
                        r_result <= r_fast ? r_fast_res : w_final;
`else
                        r_result <= w_final;
`endif
                        r_tag_out <= r_tag_in;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign result_o    = r_result;
    assign tag_o       = r_tag_out;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// Module      : tb_mdu_iter
// Description : Self-checking bench for mdu_iter against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_iter;

    localparam int W  = 32;
    localparam int TW = 5;
`ifdef MDU_FAST_SPECIAL_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [2:0]    op_i;
    logic [W-1:0]  src1_i;
    logic [W-1:0]  src2_i;
    logic [TW-1:0] tag_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  result_o;
    logic [TW-1:0] tag_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mdu_iter #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o)
    );

    // Reference arithmetic: full 64-bit products of extended operands, native division.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        if (op[2])
            special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else
            special = (a == 0) || (b == 0);
        return (FAST_EN && special) ? 1 : W;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one request from idle, wait (bounded) for the result and consume it.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TW-1:0] tag, output logic [31:0] res,
                          output logic [TW-1:0] tg, output int lat);
        @(negedge clk);
        op_i = op; src1_i = a; src2_i = b; tag_i = tag; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result_o;
        tg  = tag_o;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        op_i = '0; src1_i = '0; src2_i = '0; tag_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== '0 || tag_o !== '0)
            $display("FAIL reset_state: ready=%b valid=%b result=%h tag=%h, required 1 0 0 0",
                     in_ready_o, out_valid_o, result_o, tag_o);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [2:0]  v_op [15] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                   3'd5, 3'd7, 3'd4, 3'd6, 3'd0, 3'd4, 3'd6};
        logic [31:0] v_a  [15] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                   32'h8000_0000, 32'h8000_0000, 32'd0, 32'd5, 32'hFFFF_FFFB};
        logic [31:0] v_b  [15] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'd0, 32'd0};
        logic [31:0] v_x  [15] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                   32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                                   32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        logic [31:0]   res;
        logic [TW-1:0] tg;
        logic [TW-1:0] tag;
        int            lat;
        for (int i = 0; i < 15; i++) begin
            tag = (i == 0) ? 5'h0A : TW'(i + 16);
            run_op(v_op[i], v_a[i], v_b[i], tag, res, tg, lat);
            n_checks++;
            if (res !== v_x[i])
                $display("FAIL directed_result[%0d] op=%0d: got %h, required %h", i, v_op[i], res, v_x[i]);
            else n_pass++;
            n_checks++;
            if (tg !== tag)
                $display("FAIL directed_tag[%0d]: got %h, required %h", i, tg, tag);
            else n_pass++;
            n_checks++;
            if (lat != exp_latency(v_op[i], v_a[i], v_b[i]))
                $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat,
                         exp_latency(v_op[i], v_a[i], v_b[i]));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [2:0]    op;
        logic [31:0]   a, b, res;
        logic [TW-1:0] tag, tg;
        int            lat;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick_operand();
            b   = pick_operand();
            tag = TW'($urandom);
            run_op(op, a, b, tag, res, tg, lat);
            n_checks++;
            if (res !== ref_result(op, a, b) || tg !== tag || lat != exp_latency(op, a, b))
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got res=%h tag=%h lat=%0d, required res=%h tag=%h lat=%0d",
                         i, op, a, b, res, tg, lat, ref_result(op, a, b), tag, exp_latency(op, a, b));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]   r0;
        logic [TW-1:0] t0;
        int            lat;
        out_ready_i = 1'b0;
        @(negedge clk);
        op_i = 3'd1; src1_i = 32'hDEAD_BEEF; src2_i = 32'h1357_9BDF; tag_i = 5'h03; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r0 = result_o;
        t0 = tag_o;
        n_checks++;
        if (r0 !== ref_result(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF) || t0 !== 5'h03)
            $display("FAIL bp_first_result: got %h tag %h, required %h tag 03", r0, t0,
                     ref_result(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF));
        else n_pass++;
        // A new request is presented while the result is stalled.
        op_i = 3'd5; src1_i = 32'd1000; src2_i = 32'd33; tag_i = 5'h11; in_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (result_o !== r0 || tag_o !== t0 || in_ready_o !== 1'b0 || out_valid_o !== 1'b1)
                $display("FAIL bp_hold[%0d]: result=%h tag=%h ready=%b valid=%b, required %h %h 0 1",
                         c, result_o, tag_o, in_ready_o, out_valid_o, r0, t0);
            else n_pass++;
        end
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0)
            $display("FAIL bp_release: ready=%b valid=%b, required 1 0", in_ready_o, out_valid_o);
        else n_pass++;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (result_o !== 32'd30 || tag_o !== 5'h11 || lat != W)
            $display("FAIL back_to_back: result=%h tag=%h lat=%0d, required 0000001e 11 %0d",
                     result_o, tag_o, lat, W);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [31:0]   res;
        logic [TW-1:0] tg;
        int            lat;
        bit            seen;
        @(negedge clk);
        op_i = 3'd5; src1_i = 32'd50000; src2_i = 32'd7; tag_i = 5'h05; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0)
            $display("FAIL flush_idle: ready=%b valid=%b, required 1 0", in_ready_o, out_valid_o);
        else n_pass++;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid_o) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0)
            $display("FAIL flush_no_result: out_valid seen=%b, required 0", seen);
        else n_pass++;
        // Flush coinciding with a request drops the request.
        @(negedge clk);
        op_i = 3'd0; src1_i = 32'd3; src2_i = 32'd4; tag_i = 5'h06; in_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0; flush_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b1)
            $display("FAIL flush_vs_accept: ready=%b, required 1", in_ready_o);
        else n_pass++;
        run_op(3'd5, 32'd9, 32'd3, 5'h07, res, tg, lat);
        n_checks++;
        if (res !== 32'd3 || tg !== 5'h07 || lat != W)
            $display("FAIL after_flush: result=%h tag=%h lat=%0d, required 00000003 07 %0d", res, tg, lat, W);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0]   res;
        logic [TW-1:0] tg;
        int            lat;
        @(negedge clk);
        op_i = 3'd0; src1_i = 32'h1234; src2_i = 32'h5678; tag_i = 5'h1F; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== '0 || tag_o !== '0)
            $display("FAIL reset_mid_calc: ready=%b valid=%b result=%h tag=%h, required 1 0 0 0",
                     in_ready_o, out_valid_o, result_o, tag_o);
        else n_pass++;
        run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'h09, res, tg, lat);
        n_checks++;
        if (res !== ref_result(3'd6, 32'hFFFF_FF9C, 32'd7) || tg !== 5'h09)
            $display("FAIL after_reset: result=%h tag=%h, required %h 09", res, tg,
                     ref_result(3'd6, 32'hFFFF_FF9C, 32'd7));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
